sccb_target: RTL

- SCCB/I2C target (responder) on the camera control bus; the counterpart of the camera-init I2C master.
- Decodes START, device address, register pointer, write data and read requests arriving on SIOC/SIOD.
- Exposes register writes and reads to an external register bank through a simple strobe/address/data interface.
- Use cases: OV7670 register-map emulation in system simulation, and an FPGA-side control slave for loopback bring-up.

---
 rtl/cam_sccb_pkg.sv | 9 +
 rtl/sccb_sync_edge.sv | 29 ++
 rtl/sccb_target.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cam_sccb_pkg.sv
// cam_sccb_pkg: shared state encoding and constants for the SCCB target.
package cam_sccb_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_ACK_DEV, ST_REG_ADDR, ST_ACK_REG,
        ST_WR_DATA, ST_ACK_WR, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
    } state_e;
    localparam logic [7:0] OV7670_SCCB_ADDR = 8'h42;
    localparam int BIT_CNT_W = 4;
endpackage

// File: rtl/sccb_sync_edge.sv
// sccb_sync_edge: synchronizes SIOC/SIOD and flags SCL edges plus START/STOP.
module sccb_sync_edge (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_scl,
    input  logic i_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);
    logic [2:0] scl_q, sda_q;
    // Reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            scl_q <= '1;
            sda_q <= '1;
        end else begin
            scl_q <= {scl_q[1:0], i_scl};
            sda_q <= {sda_q[1:0], i_sda};
        end
    end
    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
endmodule

// File: rtl/sccb_target.sv
// sccb_target: SCCB/I2C responder exposing bus writes and reads to a register bank.
module sccb_target
    import cam_sccb_pkg::*;
#(
    parameter int         CLK_F    = 27_000_000,
    parameter logic [7:0] DEV_ADDR = OV7670_SCCB_ADDR,
    parameter int         AUTO_INC = 1
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic [7:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic       o_busy
);
    logic scl_rise, scl_fall, start_det, stop_det, sda_s;
    sccb_sync_edge u_sync (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_scl    (i_scl),
        .i_sda    (i_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_s    (sda_s)
    );
    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]           shift_q, shift_d, ptr_q, ptr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic                 oe_q, oe_d, wr_valid_q, wr_valid_d, busy_q, busy_d, rw_q, rw_d;
    logic                 shifting, byte_done;
    logic [7:0]           ptr_inc;
    assign shifting  = state_q inside {ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA};
    assign byte_done = cnt_q == BIT_CNT_W'(8);
    assign ptr_inc   = ptr_q + ((AUTO_INC != 0) ? 8'd1 : 8'd0);
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        if (stop_det) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else if (start_det) begin
            state_d = ST_DEV_ADDR;
            oe_d    = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end else if (scl_rise) begin
            if (shifting && !byte_done) begin
                shift_d = {shift_q[6:0], sda_s};
                cnt_d   = cnt_q + BIT_CNT_W'(1);
            end else if (state_q == ST_RD_ACK) begin
                state_d = sda_s ? ST_WAIT_STOP : state_q;
                ptr_d   = sda_s ? ptr_q : ptr_inc;
                cnt_d   = sda_s ? cnt_q : BIT_CNT_W'(1);
            end
        end else if (scl_fall) begin
            case (state_q)
                ST_DEV_ADDR: if (byte_done) begin
                    cnt_d   = '0;
                    rw_d    = shift_q[0];
                    oe_d    = shift_q[7:1] == DEV_ADDR[7:1];
                    state_d = oe_d ? ST_ACK_DEV : ST_WAIT_STOP;
                end
                ST_REG_ADDR: if (byte_done) begin
                    cnt_d   = '0;
                    ptr_d   = shift_q;
                    oe_d    = 1'b1;
                    state_d = ST_ACK_REG;
                end
                ST_WR_DATA: if (byte_done) begin
                    cnt_d      = '0;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = ptr_q;
                    wr_data_d  = shift_q;
                    ptr_d      = ptr_inc;
                    oe_d       = 1'b1;
                    state_d    = ST_ACK_WR;
                end
                ST_ACK_REG, ST_ACK_WR: begin
                    oe_d    = 1'b0;
                    state_d = ST_WR_DATA;
                end
                ST_ACK_DEV, ST_RD_ACK: if (state_q == ST_ACK_DEV ? rw_q : cnt_q == BIT_CNT_W'(1)) begin
                    shift_d = i_rd_data;
                    oe_d    = ~i_rd_data[7];
                    cnt_d   = BIT_CNT_W'(1);
                    state_d = ST_RD_DATA;
                end else if (state_q == ST_ACK_DEV) begin
                    oe_d    = 1'b0;
                    state_d = ST_REG_ADDR;
                end
                ST_RD_DATA: if (byte_done) begin
                    oe_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RD_ACK;
                end else begin
                    shift_d = {shift_q[6:0], 1'b0};
                    oe_d    = ~shift_q[6];
                    cnt_d   = cnt_q + BIT_CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end
    assign o_sda_oe   = oe_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_rd_addr  = ptr_q;
    assign o_busy     = busy_q;
    a_clk_f: assert property (@(posedge i_clk) CLK_F >= 16);
endmodule
